// File: rtl/mem_port_arbiter.sv
// Shares one physical memory port between instruction fetch and data load/store.
// One transaction in flight at a time; simultaneous requests alternate round-robin.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_read,
  input  logic [ADDR_WIDTH-1:0]   i_address,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_resp,
  input  logic                    d_read,
  input  logic                    d_write,
  input  logic [DATA_WIDTH/8-1:0] d_wmask,
  input  logic [ADDR_WIDTH-1:0]   d_address,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_resp,
  output logic                    pmem_read,
  output logic                    pmem_write,
  output logic [DATA_WIDTH/8-1:0] pmem_wmask,
  output logic [ADDR_WIDTH-1:0]   pmem_address,
  output logic [DATA_WIDTH-1:0]   pmem_wdata,
  input  logic [DATA_WIDTH-1:0]   pmem_rdata,
  input  logic                    pmem_resp
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_e;
  typedef enum logic {GRANT_I, GRANT_D} grant_e;

  state_e                    state_q;
  grant_e                    last_grant_q;
  logic                      pmem_read_q;
  logic                      pmem_write_q;
  logic [DATA_WIDTH/8-1:0]   pmem_wmask_q;
  logic [ADDR_WIDTH-1:0]     pmem_address_q;
  logic [DATA_WIDTH-1:0]     pmem_wdata_q;

  logic i_req;
  logic d_req;
  logic grant_i;
  logic grant_d;

  // On a tie the side that did not win last time gets the port.
  always_comb begin
    i_req   = i_read;
    d_req   = d_read | d_write;
    grant_i = i_req & (~d_req | (last_grant_q == GRANT_D));
    grant_d = d_req & ~grant_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      last_grant_q   <= GRANT_D;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_wmask_q   <= '0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_i) begin
            state_q        <= I_BUSY;
            last_grant_q   <= GRANT_I;
            pmem_read_q    <= 1'b1;
            pmem_write_q   <= 1'b0;
            pmem_wmask_q   <= '0;
            pmem_address_q <= i_address;
            pmem_wdata_q   <= '0;
          end else if (grant_d) begin
            state_q        <= D_BUSY;
            last_grant_q   <= GRANT_D;
            pmem_read_q    <= ~d_write;
            pmem_write_q   <= d_write;
            pmem_wmask_q   <= d_write ? d_wmask : '0;
            pmem_address_q <= d_address;
            pmem_wdata_q   <= d_wdata;
          end
        end
        I_BUSY, D_BUSY: begin
          if (pmem_resp) begin
            state_q        <= IDLE;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_wmask_q   <= '0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_wmask   = pmem_wmask_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;

  assign i_resp  = (state_q == I_BUSY) & pmem_resp;
  assign d_resp  = (state_q == D_BUSY) & pmem_resp;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized checks of the memory port arbiter against a
// transaction-level model of the grant order and per-transaction port values.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_read;
  logic [31:0] i_address;
  logic [31:0] i_rdata;
  logic        i_resp;
  logic        d_read;
  logic        d_write;
  logic [3:0]  d_wmask;
  logic [31:0] d_address;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [3:0]  pmem_wmask;
  logic [31:0] pmem_address;
  logic [31:0] pmem_wdata;
  logic [31:0] pmem_rdata;
  logic        pmem_resp;

  int unsigned ntests = 0;
  int unsigned nfail  = 0;
  bit          exp_last_i;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_wmask(d_wmask), .d_address(d_address),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wmask(pmem_wmask),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    ntests++;
    assert (obs === exp_v) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_pmem_read"},  pmem_read,  0);
    chk({tag, "_pmem_write"}, pmem_write, 0);
    chk({tag, "_i_resp"},     i_resp,     0);
    chk({tag, "_d_resp"},     d_resp,     0);
  endtask

  // 0 = nobody, 1 = instruction side, 2 = data side
  function automatic int pick(input bit ir, input bit dr);
    if (ir && dr) return exp_last_i ? 2 : 1;
    if (ir)       return 1;
    if (dr)       return 2;
    return 0;
  endfunction

  // Called in an IDLE cycle with requests already driven; runs one full transaction.
  task automatic serve(input int unsigned lat, input logic [31:0] rd,
                       input bit scramble, input bit keep);
    int          owner;
    logic [31:0] ea;
    logic [31:0] ew;
    logic [3:0]  em;
    bit          wr;
    owner = pick(i_read, d_read | d_write);
    chk("grant_exists", owner != 0, 1);
    if (owner == 1) begin
      ea = i_address; wr = 1'b0; ew = '0; em = '0;
    end else begin
      ea = d_address; wr = d_write; ew = d_wdata; em = d_write ? d_wmask : 4'h0;
    end
    exp_last_i = (owner == 1);
    for (int unsigned k = 0; k <= lat; k++) begin
      tick();
      if (scramble && k > 0) begin
        i_address = $urandom;
        d_address = $urandom;
        d_wdata   = $urandom;
        d_wmask   = 4'($urandom);
      end
      #1;
      chk("busy_pmem_read",  pmem_read,    !wr);
      chk("busy_pmem_write", pmem_write,   wr);
      chk("busy_pmem_addr",  pmem_address, ea);
      chk("busy_pmem_wmask", pmem_wmask,   em);
      if (wr) chk("busy_pmem_wdata", pmem_wdata, ew);
      chk("busy_i_resp", i_resp, 0);
      chk("busy_d_resp", d_resp, 0);
    end
    pmem_resp  = 1'b1;
    pmem_rdata = rd;
    #1;
    chk("done_i_resp", i_resp, owner == 1);
    chk("done_d_resp", d_resp, owner == 2);
    if (owner == 1) chk("done_i_rdata", i_rdata, rd);
    else            chk("done_d_rdata", d_rdata, rd);
    chk("done_strobe_held", pmem_read | pmem_write, 1);
    tick();
    pmem_resp = 1'b0;
    if (!keep) begin
      if (owner == 1) i_read = 1'b0;
      else begin d_read = 1'b0; d_write = 1'b0; end
    end
    #1;
    check_idle("after_done");
  endtask

  initial begin
    int unsigned op;
    rst = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_address = '0; d_address = '0; d_wdata = '0; d_wmask = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    exp_last_i = 1'b0;
    #2;
    check_idle("reset");
    chk("reset_pmem_addr",  pmem_address, 0);
    chk("reset_pmem_wmask", pmem_wmask,   0);
    chk("reset_pmem_wdata", pmem_wdata,   0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Instruction fetch with a three-cycle memory.
    i_read = 1'b1; i_address = 32'h60;
    serve(2, 32'h0000_0013, 1'b0, 1'b0);

    // Byte-masked data write.
    d_write = 1'b1; d_address = 32'h1004; d_wdata = 32'hDEAD_BEEF; d_wmask = 4'b0011;
    serve(1, 32'h5555_AAAA, 1'b0, 1'b0);

    // Tie from reset: I, then D while I keeps requesting, then I again.
    rst = 1'b0; #1; tick(); rst = 1'b1; exp_last_i = 1'b0; tick();
    i_read = 1'b1; d_read = 1'b1; i_address = 32'h100; d_address = 32'h200;
    serve(1, 32'h1111_0000, 1'b0, 1'b1);
    serve(2, 32'h2222_0000, 1'b1, 1'b1);
    serve(0, 32'h3333_0000, 1'b0, 1'b0);
    serve(0, 32'h4444_0000, 1'b0, 1'b0);

    // Memory response with nobody busy.
    pmem_resp = 1'b1; pmem_rdata = 32'hFFFF_FFFF;
    #1; check_idle("idle_resp");
    tick(); pmem_resp = 1'b0;
    #1; check_idle("idle_resp_after");

    // Reset during an instruction fetch, then a stale memory response.
    i_read = 1'b1; i_address = 32'h80;
    tick(); #1;
    chk("pre_rst_pmem_read", pmem_read, 1);
    rst = 1'b0; #1;
    chk("async_rst_pmem_read", pmem_read,    0);
    chk("async_rst_pmem_addr", pmem_address, 0);
    i_read = 1'b0;
    tick();
    rst = 1'b1; pmem_resp = 1'b1;
    #1; check_idle("late_resp");
    tick(); pmem_resp = 1'b0; exp_last_i = 1'b0;
    i_read = 1'b1; i_address = 32'h84;
    serve(1, 32'h0000_1234, 1'b0, 1'b0);

    // Randomized traffic; the waiting side keeps its request asserted.
    for (int n = 0; n < 80; n++) begin
      if (!i_read && $urandom_range(0, 1) == 1) begin
        i_read = 1'b1; i_address = $urandom;
      end
      if (!(d_read | d_write) && $urandom_range(0, 1) == 1) begin
        op = $urandom_range(0, 2);
        d_read = (op != 1); d_write = (op != 0);
        d_address = $urandom; d_wdata = $urandom; d_wmask = 4'($urandom);
      end
      if (!i_read && !(d_read | d_write)) begin
        pmem_resp = $urandom_range(0, 1) == 1;
        #1; check_idle("rand_idle");
        tick(); pmem_resp = 1'b0;
      end else begin
        serve($urandom_range(0, 3), $urandom, $urandom_range(0, 1) == 1, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
